// File: rtl/ucaspian_synapse.sv
// Synapse stage: walks axon-supplied synapse ranges through the synapse RAM and streams
// (target, weight) events downstream. Optional macro: UCASPIAN_SYN_ZERO_SKIP_EN.
module ucaspian_synapse (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        clear_config,
   output logic        clear_done,
   input  logic [11:0] config_addr,
   input  logic [7:0]  config_value,
   input  logic        config_byte,
   input  logic        config_enable,
   input  logic        next_step,
   output logic        step_done,
   input  logic [11:0] syn_start,
   input  logic [11:0] syn_end,
   input  logic        syn_vld,
   output logic        syn_rdy,
   output logic [7:0]  dend_addr,
   output logic [7:0]  dend_weight,
   output logic        dend_vld,
   input  logic        dend_rdy
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [15:0] ram [0:4095];
   logic        ram_we;
   logic [11:0] ram_waddr;
   logic [15:0] ram_wdata;
   logic [15:0] rd_data;

   logic [7:0]  stage_target;
   logic [11:0] clr_cnt;
   logic        clr_sat;

   logic [0:0]  state;
   logic [11:0] cur;
   logic [11:0] last;
   logic        live;
   logic        inflight;
   logic        rd_issue;
   logic        accept;

   logic [15:0] fifo [0:1];
   logic        wptr;
   logic        rptr;
   logic [1:0]  count;
   logic        push;
   logic        pop;
   logic        keep;
   logic [2:0]  occ;

   // Write port is shared by clearing and configuration; clearing wins.
   always_comb begin
      ram_we    = clear_config || (config_enable && config_byte);
      ram_waddr = clear_config ? clr_cnt : config_addr;
      ram_wdata = clear_config ? '0 : {stage_target, config_value};
   end

   always_ff @(posedge clk) begin
      if (ram_we)
         ram[ram_waddr] <= ram_wdata;
      if (rd_issue)
         rd_data <= ram[cur];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_target <= '0;
         clr_cnt      <= '0;
         clr_sat      <= 1'b0;
         clear_done   <= 1'b0;
      end else begin
         if (config_enable && !config_byte)
            stage_target <= config_value;
         if (clear_config) begin
            if (clr_cnt == 12'hFFF)
               clr_sat <= 1'b1;
            else
               clr_cnt <= clr_cnt + 12'd1;
         end else begin
            clr_cnt <= '0;
            clr_sat <= 1'b0;
         end
         clear_done <= clear_config && clr_sat;
      end
   end

`ifdef UCASPIAN_SYN_ZERO_SKIP_EN
   assign keep = (rd_data[7:0] != 8'd0);
`else
   assign keep = 1'b1;
`endif

   always_comb begin
      dend_vld    = (count != 2'd0);
      dend_addr   = fifo[rptr][15:8];
      dend_weight = fifo[rptr][7:0];
      pop         = dend_vld && dend_rdy;
      push        = inflight && keep;
      // Occupancy counts the read in flight so the FIFO can never overflow.
      occ         = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
      rd_issue    = (state == S_RUN) && !clear_config && (occ < 3'd2);
      syn_rdy     = live && (state == S_IDLE) && enable && !clear_config;
      accept      = syn_vld && syn_rdy;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         cur      <= '0;
         last     <= '0;
         live     <= 1'b0;
         inflight <= 1'b0;
      end else begin
         live     <= 1'b1;
         inflight <= rd_issue;
         if (clear_config) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept) begin
                     cur   <= syn_start;
                     last  <= (syn_end < syn_start) ? syn_start : syn_end;
                     state <= S_RUN;
                  end
               end
               default: begin
                  if (rd_issue) begin
                     if (cur == last)
                        state <= S_IDLE;
                     else
                        cur <= cur + 12'd1;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo[0] <= '0;
         fifo[1] <= '0;
         wptr    <= 1'b0;
         rptr    <= 1'b0;
         count   <= '0;
      end else if (clear_config) begin
         wptr  <= 1'b0;
         rptr  <= 1'b0;
         count <= '0;
      end else begin
         if (push) begin
            fifo[wptr] <= rd_data;
            wptr       <= ~wptr;
         end
         if (pop)
            rptr <= ~rptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         step_done <= 1'b0;
      else
         step_done <= !next_step && (state == S_IDLE) && !syn_vld &&
                      (count == 2'd0) && !inflight && !clear_config;
   end

endmodule

// File: doc/ucaspian_synapse.md
# ucaspian_synapse

Synapse stage: sits directly downstream of the axon stage and upstream of the dendrite/neuron accumulator. Accepts one inclusive synapse-index range per axon fire, walks it through a 4096-entry synapse RAM (target neuron + signed weight), and streams one (target, weight) event per synapse to the dendrite side with full backpressure. Also owns synapse configuration writes and RAM clearing.

## Interface
- No parameters; sizes fixed: 4096 synapses, 8-bit neuron ids, 8-bit signed weights.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  low: no new range accepted; bursts in progress finish.
- clear_config  in  1  level; zero all synapse RAM entries.
- clear_done  out  1  registered; high while clear_config is held and the sweep has completed.
- config_addr  in  12  synapse index to configure.
- config_value  in  8  configuration byte.
- config_byte  in  1  0: target neuron byte; 1: weight byte, commits the write.
- config_enable  in  1  config byte strobe.
- next_step  in  1  timestep boundary pulse.
- step_done  out  1  registered; stage is quiescent.
- syn_start  in  12  first synapse index, inclusive.
- syn_end  in  12  last synapse index, inclusive.
- syn_vld  in  1  range valid.
- syn_rdy  out  1  range accepted when syn_vld && syn_rdy.
- dend_addr  out  8  target neuron id.
- dend_weight  out  8  signed weight.
- dend_vld  out  1  event valid.
- dend_rdy  in  1  event consumed when dend_vld && dend_rdy.

## Operation
- Synapse RAM: 16x4096 dual-port, 1-cycle registered read. Entry [15:8] target, [7:0] weight. Write port owned solely by config/clear logic.
- Config: byte 0 loads staging target; byte 1 writes {staging target, config_value} to config_addr. Writes only legal between bursts (host protocol); no arbitration.
- Clear: while clear_config high, one entry zeroed per cycle at 0..4095, counter saturates at 4095, then clear_done. Dropping clear_config resets the counter. clear_config also aborts any burst, flushes FIFO and in-flight read.
- FSM IDLE / RUN:
  - IDLE: syn_rdy = enable && !clear_config. On accept latch cur = syn_start, last = syn_end; go RUN.
  - RUN: issue read at cur when (fifo_count - pop + inflight) < 2. After issuing cur == last, return to IDLE; otherwise cur += 1. cur never wraps; equality is checked before increment.
  - syn_end < syn_start is treated as single-synapse range (only syn_start read).
- Read data enters a 2-entry output FIFO one cycle after issue; FIFO head drives dend_addr/dend_weight/dend_vld.
- step_done registered = IDLE && !syn_vld && fifo empty && no read in flight && !clear_config; forced 0 in the cycle after next_step.

## Timing
- Reset values: syn_rdy 0, dend_vld 0, dend_addr 0, dend_weight 0, step_done 0, clear_done 0; FSM IDLE, FIFO empty.
- Reset asserted mid-burst: everything returns to reset values immediately; the burst is lost.
- Latency: range accepted at edge T, read issued at T+1, dend_vld high after edge T+2.
- Throughput: 1 event/cycle with dend_rdy held high. dend_rdy low: at most 2 buffered events, reads stall, and no event is dropped or duplicated.
- Next range is accepted earliest in the cycle after the last read is issued, so back-to-back ranges have a 1-cycle bubble.
- dend_addr/dend_weight stable while dend_vld && !dend_rdy.

## Configuration
- UCASPIAN_SYN_ZERO_SKIP_EN defined: entries with weight == 0 are read but not pushed to the FIFO; burst cycle count is unchanged, dendrite traffic is reduced.
- Undefined: every synapse in the range is emitted, including zero weights.

## Test plan
- Configure synapse 10 = (target 0x05, weight 0x7F), send range 10..10 with dend_rdy=1 -> one event (0x05, 0x7F) two cycles after accept, then step_done=1.
- Range 100..103 with distinct entries and dend_rdy=1 -> four events on consecutive cycles, in index order.
- Range 0..7 with dend_rdy toggling 1/0 randomly -> exactly 8 events in order, with no duplicates or losses.
- Range 4094..4095 -> two events, then IDLE; cur does not wrap to 0.
- Assert reset mid-burst of 0..50 -> dend_vld=0 immediately; after release step_done=1 and no residual events. Assert clear_config for 4100 cycles -> clear_done high; a subsequent range 0..3 yields weights 0, or no events when UCASPIAN_SYN_ZERO_SKIP_EN is defined.
